// File: rtl/fpga_link_pkg.sv
// Shared definitions for the two-board ReLU link: default data width,
// the z value type, the Board-1 transmit FSM states and the saturating
// conversion also used by Board-2 test models.
package fpga_link_pkg;

    localparam int DATA_W = 4;

    typedef logic signed [DATA_W-1:0] z_t;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } tx_state_t;

    // Clamp a wide signed accumulator into the signed DATA_W range.
    function automatic z_t sat_to_z(input logic signed [31:0] acc);
        int zmax;
        int zmin;
        zmax = (1 << (DATA_W - 1)) - 1;
        zmin = -(1 << (DATA_W - 1));
        if (acc > zmax) begin
            return z_t'(zmax);
        end else if (acc < zmin) begin
            return z_t'(zmin);
        end else begin
            return z_t'(acc);
        end
    endfunction

endpackage

// File: rtl/fpga1_z_tx_hold_timer.sv
// hold_timer: loadable down-counter that times the GPIO hold window.
// done_o is high while the count is zero.
module hold_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign done_o = (cnt_q == '0);

    // Next count: load has priority, otherwise count down to zero while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && !done_o) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fpga1_z_tx.sv
// fpga1_z_tx: Board-1 side of the ReLU link. Accumulates z = sum(x*w) over
// N_TERMS valid/ready beats, then drives z onto a registered GPIO bus and
// holds it for HOLD_CYCLES cycles before accepting the next frame.
// Build option: define FPGA1_SAT_EN to clamp z to the signed DATA_W range;
// otherwise z is the low DATA_W bits of the accumulator (two's-complement wrap).
module fpga1_z_tx #(
    parameter int DATA_W      = 4,
    parameter int N_TERMS     = 4,
    parameter int HOLD_CYCLES = 5_000_000
) (
    input  logic                     CLOCK_50,
    input  logic [0:0]               KEY,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] w_in,
    output logic [DATA_W-1:0]        GPIO_OUT,
    output logic                     z_valid,
    output logic                     busy
);

    import fpga_link_pkg::*;

    localparam int ACC_W  = 2 * DATA_W + $clog2(N_TERMS) + 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam int HLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(N_TERMS - 1);
    localparam logic [HLD_W-1:0] HOLD_LOAD = HLD_W'(HOLD_CYCLES - 1);

`ifdef FPGA1_SAT_EN
    localparam logic signed [ACC_W-1:0] Z_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Z_MIN = ACC_W'(-(1 << (DATA_W - 1)));
`endif

    logic                     rst_n;
    tx_state_t                state_q;
    tx_state_t                state_d;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_d;
    logic [DATA_W-1:0]        gpio_q;
    logic [DATA_W-1:0]        gpio_d;
    logic                     zv_q;
    logic                     zv_d;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_next;
    logic [DATA_W-1:0]        z_new;
    logic                     hs;
    logic                     last_beat;
    logic                     hold_load;
    logic                     hold_done;

    assign rst_n     = KEY[0];
    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q == HOLD);
    assign hs        = in_valid & in_ready;
    assign last_beat = (cnt_q == LAST_CNT);

    assign GPIO_OUT  = gpio_q;
    assign z_valid   = zv_q;

    // Full-width signed product, sign-extended into the accumulator.
    always_comb begin
        prod     = x_in * w_in;
        acc_next = acc_q + $signed({{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod});
    end

    // Reduce the completed sum to the bus width.
    always_comb begin
`ifdef FPGA1_SAT_EN
        if (acc_next > Z_MAX) begin
            z_new = Z_MAX[DATA_W-1:0];
        end else if (acc_next < Z_MIN) begin
            z_new = Z_MIN[DATA_W-1:0];
        end else begin
            z_new = acc_next[DATA_W-1:0];
        end
`else
        z_new = acc_next[DATA_W-1:0];
`endif
    end

    // Next-state logic: accumulate beats, load GPIO on the last one, then hold.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        gpio_d    = gpio_q;
        zv_d      = 1'b0;
        hold_load = 1'b0;
        case (state_q)
            ACCUM: begin
                if (hs) begin
                    if (last_beat) begin
                        gpio_d    = z_new;
                        zv_d      = 1'b1;
                        acc_d     = '0;
                        cnt_d     = '0;
                        hold_load = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        acc_d = acc_next;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (hold_done) begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State, accumulator and output registers.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            gpio_q  <= '0;
            zv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            gpio_q  <= gpio_d;
            zv_q    <= zv_d;
        end
    end

    hold_timer #(
        .CNT_W(HLD_W)
    ) u_hold_timer (
        .clk_i      (CLOCK_50),
        .rst_n_i    (rst_n),
        .load_i     (hold_load),
        .load_val_i (HOLD_LOAD),
        .en_i       (busy),
        .done_o     (hold_done)
    );

endmodule

// File: tb/tb_fpga1_z_tx.sv
// Self-checking bench for fpga1_z_tx with DATA_W=4, N_TERMS=4, HOLD_CYCLES=4.
// Expected z values are queued when a frame's last beat is driven and
// compared when the DUT pulses z_valid.
module tb_fpga1_z_tx;

    logic              CLOCK_50;
    logic [0:0]        KEY;
    logic              in_valid;
    logic              in_ready;
    logic signed [3:0] x_in;
    logic signed [3:0] w_in;
    logic [3:0]        GPIO_OUT;
    logic              z_valid;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;
    int zv_count = 0;
    int n_pushed = 0;
    logic [3:0] exp_q[$];
    logic       stab_en = 1'b0;
    logic [3:0] gpio_prev = '0;

    fpga1_z_tx #(
        .DATA_W      (4),
        .N_TERMS     (4),
        .HOLD_CYCLES (4)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .KEY      (KEY),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_in     (x_in),
        .w_in     (w_in),
        .GPIO_OUT (GPIO_OUT),
        .z_valid  (z_valid),
        .busy     (busy)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [3:0] expz(input int s);
`ifdef FPGA1_SAT_EN
        if (s > 7) return 4'b0111;
        if (s < -8) return 4'b1000;
        return 4'(s);
`else
        return 4'(s);
`endif
    endfunction

    // Scoreboard side: every z_valid pulse must match the oldest queued frame.
    always @(negedge CLOCK_50) begin
        if (KEY[0]) begin
            if (z_valid) begin
                logic [3:0] e;
                zv_count++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL zv_unexpected: z_valid high with GPIO_OUT=%b, no frame expected", GPIO_OUT);
                end else begin
                    e = exp_q.pop_front();
                    if (GPIO_OUT !== e) begin
                        n_fail++;
                        $display("FAIL sb_gpio: GPIO_OUT=%b expected %b", GPIO_OUT, e);
                    end
                end
            end else if (stab_en) begin
                n_checks++;
                if (GPIO_OUT !== gpio_prev) begin
                    n_fail++;
                    $display("FAIL gpio_stable: GPIO_OUT=%b expected %b (no z_valid)", GPIO_OUT, gpio_prev);
                end
            end
            gpio_prev = GPIO_OUT;
        end
    end

    // Present one beat from a negedge; returns after the accepting posedge.
    task automatic send_beat(input int x, input int w, output int waits);
        in_valid = 1'b1;
        x_in     = 4'(x);
        w_in     = 4'(w);
        waits    = 0;
        while (!in_ready && waits < 20) begin
            @(negedge CLOCK_50);
            waits++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_timeout: in_ready=%b expected 1 within 20 cycles", in_ready);
        end
        @(negedge CLOCK_50);
    endtask

    task automatic send_frame(input int xs[4], input int ws[4], input bit keep_valid,
                              output int first_waits);
        int sum;
        int wt;
        sum = 0;
        for (int i = 0; i < 4; i++) sum += xs[i] * ws[i];
        first_waits = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                exp_q.push_back(expz(sum));
                n_pushed++;
            end
            send_beat(xs[i], ws[i], wt);
            if (i == 0) first_waits = wt;
        end
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge CLOCK_50);
            n++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL ready_timeout: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_reset();
        KEY      = 1'b1;
        in_valid = 1'b0;
        x_in     = '0;
        w_in     = '0;
        #2 KEY   = 1'b0;
        in_valid = 1'b1;
        x_in     = 4'sd7;
        w_in     = 4'sd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK_50);
            n_checks++;
            if (GPIO_OUT !== 4'b0000 || z_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_state: GPIO=%b zv=%b busy=%b rdy=%b expected 0000 0 0 1",
                         GPIO_OUT, z_valid, busy, in_ready);
            end
        end
        in_valid = 1'b0;
        KEY      = 1'b1;
        @(negedge CLOCK_50);
    endtask

    task automatic test_normal();
        int wt;
        send_frame('{1, 2, -1, 0}, '{1, 1, 1, 3}, 1'b0, wt);
        n_checks++;
        if (wt !== 0) begin
            n_fail++;
            $display("FAIL first_beat_wait: waited %0d expected 0", wt);
        end
        n_checks++;
        if (GPIO_OUT !== 4'b0010 || z_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL normal_load: GPIO=%b zv=%b expected 0010 1", GPIO_OUT, z_valid);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: rdy=%b busy=%b expected 0 1", k, in_ready, busy);
            end
            @(negedge CLOCK_50);
        end
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || z_valid !== 1'b0 || GPIO_OUT !== 4'b0010) begin
            n_fail++;
            $display("FAIL hold_end: rdy=%b busy=%b zv=%b GPIO=%b expected 1 0 0 0010",
                     in_ready, busy, z_valid, GPIO_OUT);
        end
        n_checks++;
        if (zv_count !== 1) begin
            n_fail++;
            $display("FAIL zv_pulses: count=%0d expected 1", zv_count);
        end
    endtask

    task automatic test_overflow();
        int wt;
        send_frame('{7, 7, 7, 7}, '{7, 7, 7, 7}, 1'b0, wt);
        n_checks++;
`ifdef FPGA1_SAT_EN
        if (GPIO_OUT !== 4'b0111) begin
`else
        if (GPIO_OUT !== 4'b0100) begin
`endif
            n_fail++;
            $display("FAIL pos_overflow: GPIO=%b expected %b", GPIO_OUT, expz(196));
        end
        wait_ready();
        send_frame('{-8, -8, -8, -8}, '{7, 7, 7, 7}, 1'b0, wt);
        n_checks++;
`ifdef FPGA1_SAT_EN
        if (GPIO_OUT !== 4'b1000) begin
`else
        if (GPIO_OUT !== 4'b0000) begin
`endif
            n_fail++;
            $display("FAIL neg_overflow: GPIO=%b expected %b", GPIO_OUT, expz(-224));
        end
        wait_ready();
    endtask

    task automatic test_back_to_back();
        int wt;
        send_frame('{3, -2, 1, 1}, '{1, 1, 1, 1}, 1'b1, wt);
        n_checks++;
        if (GPIO_OUT !== 4'b0011) begin
            n_fail++;
            $display("FAIL b2b_first: GPIO=%b expected 0011", GPIO_OUT);
        end
        gpio_prev = GPIO_OUT;
        stab_en   = 1'b1;
        send_frame('{-1, -1, -1, 1}, '{1, 1, 1, 2}, 1'b0, wt);
        stab_en   = 1'b0;
        n_checks++;
        if (wt !== 4) begin
            n_fail++;
            $display("FAIL b2b_accept_wait: waited %0d expected 4", wt);
        end
        n_checks++;
        if (GPIO_OUT !== 4'b1111) begin
            n_fail++;
            $display("FAIL b2b_second: GPIO=%b expected 1111", GPIO_OUT);
        end
        wait_ready();
    endtask

    task automatic test_mid_reset();
        int wt;
        send_beat(3, 3, wt);
        send_beat(3, 3, wt);
        in_valid = 1'b0;
        KEY      = 1'b0;
        @(negedge CLOCK_50);
        n_checks++;
        if (GPIO_OUT !== 4'b0000 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state: GPIO=%b rdy=%b busy=%b expected 0000 1 0",
                     GPIO_OUT, in_ready, busy);
        end
        KEY = 1'b1;
        send_frame('{1, 1, 1, 1}, '{1, 1, 1, 1}, 1'b0, wt);
        n_checks++;
        if (GPIO_OUT !== 4'b0100) begin
            n_fail++;
            $display("FAIL midreset_frame: GPIO=%b expected 0100", GPIO_OUT);
        end
        wait_ready();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        repeat (3) @(negedge CLOCK_50);
        n_checks++;
        if (exp_q.size() != 0 || zv_count != n_pushed) begin
            n_fail++;
            $display("FAIL scoreboard_drain: pending=%0d pulses=%0d expected 0 %0d",
                     exp_q.size(), zv_count, n_pushed);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
